// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: adder width and multiplier FSM encoding.
package arith_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// ADDER_WIDTH-bit ripple-carry adder: {carry_out, sum} = a + b + c.
module ripple_carry_adder
  import arith_pkg::*;
(
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   c,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   carry_out
);

  logic [ADDER_WIDTH:0] cy;

  // Full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = c;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
    end
  end

  assign carry_out = cy[ADDER_WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier built on ripple_carry_adder.
//
// Handshake: start is a request sampled only in IDLE; on that edge the
// operands are captured. busy is high for the WIDTH iteration cycles, then
// done pulses for exactly one cycle with product valid. product holds until
// the next accepted start or reset. start in CALC/DONE is ignored.
// WIDTH must equal ADDER_WIDTH (the adder is fixed at 4 bits).
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] mc_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_b = mq_q[0] ? mc_q : '0;

  ripple_carry_adder u_adder (
    .a         (acc_q),
    .b         (add_b),
    .c         (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE waits for start, CALC runs WIDTH cycles, DONE lasts one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on accepted start, shift {carry, sum, Q} right in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mq_q  <= '0;
      mc_q  <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            mq_q  <= multiplier;
            mc_q  <= multiplicand;
            cnt_q <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc_q <= {add_cout, add_sum[WIDTH-1:1]};
          mq_q  <= {add_sum[0], mq_q[WIDTH-1:1]};
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign product   = {acc_q, mq_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: a timing-level model decides
// which starts are accepted and pushes M*Q; a monitor checks busy/done every
// cycle and the product on each done pulse.
module tb_shift_add_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            next_accept = 0;
  logic [PW-1:0] exp_q[$];
  int            acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one operation every W+2 cycles, reset flushes everything.
  always @(posedge clk) begin
    logic [PW-1:0] prod;
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      next_accept = cyc + 1;
    end else if (start && cyc >= next_accept) begin
      prod = PW'(mcand) * PW'(mplier);
      exp_q.push_back(prod);
      acc_q.push_back(cyc);
      next_accept = cyc + W + 2;
    end
  end

  // Monitor: busy for W cycles after acceptance, done on the W-th, product then.
  always @(negedge clk) begin
    logic busy_exp, done_exp;
    int   age;
    if (cyc > 0) begin
      busy_exp = 1'b0;
      done_exp = 1'b0;
      age      = 0;
      if (acc_q.size() > 0) begin
        age      = cyc - acc_q[0];
        busy_exp = (age < W);
        done_exp = (age == W);
      end
      check("busy", 32'(busy), 32'(busy_exp));
      check("done", 32'(done), 32'(done_exp));
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (done && exp_q.size() > 0)
        check("product", 32'(product), 32'(exp_q[0]));
      if (acc_q.size() > 0 && age >= W) begin
        void'(acc_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q);
    issue(m, q);
    tick(W + 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    tick(2);
    check("reset_product", 32'(product), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Directed products, including max carry and zero operands.
    run_op(4'd3, 4'd5);
    check("held_3x5", 32'(product), 32'd15);
    run_op(4'd15, 4'd15);
    check("held_15x15", 32'(product), 32'hE1);
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd0);

    // Start re-asserted on the second CALC cycle is ignored.
    issue(4'd2, 4'd7);
    tick(1);
    issue(4'd15, 4'd15);
    tick(W + 1);
    check("held_2x7", 32'(product), 32'd14);

    // Reset mid-operation aborts with no done.
    issue(4'd13, 4'd11);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_product", 32'(product), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    tick(8);
    run_op(4'd13, 4'd11);
    check("held_13x11", 32'(product), 32'd143);

    // Reset and start together: start dropped.
    rst   = 1'b1;
    start = 1'b1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    tick(3);

    // Random start/operand traffic with occasional resets.
    for (int i = 0; i < 200; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      mcand  = W'($urandom_range(0, 15));
      mplier = W'($urandom_range(0, 15));
      rst    = ($urandom_range(0, 60) == 0);
      tick(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick(2);

    // Back-to-back: start held high with changing operands.
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mcand  = W'($urandom_range(0, 15));
      mplier = W'($urandom_range(0, 15));
      tick(1);
    end
    start = 1'b0;

    // Drain with a bounded wait.
    waited = 0;
    while (acc_q.size() > 0 && waited < 30) begin
      tick(1);
      waited++;
    end
    n_cmp++;
    if (acc_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d operations still outstanding, expected 0", acc_q.size());
    end
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
